// File: rtl/idu_pkg.sv
// idu_pkg: opcodes, immediate/class enums and the decoded bundle shared by the decode queue.
package idu_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
    typedef enum logic [3:0] {
        CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
        CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_SYSTEM, CLS_MULDIV
    } op_class_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic        func7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        imm_type_e   imm_type;
        op_class_e   op_class;
        logic        regen;
        logic        pcjen;
        logic        pcren;
        logic        jalen;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_gen(input imm_type_e t, input logic [31:0] i);
        case (t)
            IMM_I:   imm_gen = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm_gen = {i[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm_gen = '0;
        endcase
    endfunction
endpackage

// File: rtl/idu_decode_comb.sv
// idu_decode_comb: combinational RV32I/RV32E decoder producing one dec_t bundle.
// Defining IDU_RV32M_EN decodes OP with func7=0x01 as MULDIV instead of flagging it illegal.
module idu_decode_comb
    import idu_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);
    logic [6:0] w_opc, w_f7;
    logic [2:0] w_f3, w_en;
    logic       w_known, w_regbad, w_ill;
    imm_type_e  w_typ;
    op_class_e  w_cls;

    always_comb begin
        w_opc   = i_inst[6:0];
        w_f3    = i_inst[14:12];
        w_f7    = i_inst[31:25];
        w_cls   = CLS_ALU;
        w_typ   = IMM_R;
        w_en    = 3'b000;
        w_known = 1'b1;
        case (w_opc)
            OPC_LUI:    begin w_cls = CLS_LUI;    w_typ = IMM_U; w_en = 3'b100; end
            OPC_AUIPC:  begin w_cls = CLS_AUIPC;  w_typ = IMM_U; w_en = 3'b101; end
            OPC_JAL:    begin w_cls = CLS_JAL;    w_typ = IMM_J; w_en = 3'b111; end
            OPC_JALR:   begin w_cls = CLS_JALR;   w_typ = IMM_I; w_en = 3'b110; end
            OPC_BRANCH: begin w_cls = CLS_BRANCH; w_typ = IMM_B; w_en = 3'b011; end
            OPC_LOAD:   begin w_cls = CLS_LOAD;   w_typ = IMM_I; w_en = 3'b100; end
            OPC_STORE:  begin w_cls = CLS_STORE;  w_typ = IMM_S; end
            OPC_OPIMM:  begin w_typ = IMM_I; w_en = 3'b100; end
            OPC_SYSTEM: begin w_cls = CLS_SYSTEM; w_typ = IMM_I; end
            OPC_OP: begin
                w_en    = 3'b100;
                w_known = (w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
`ifdef IDU_RV32M_EN
                if (w_f7 == 7'h01) begin
                    w_cls   = CLS_MULDIV;
                    w_known = 1'b1;
                end
`endif
            end
            default: w_known = 1'b0;
        endcase
        // RV32E: only register fields the format actually uses may exceed x15
        w_regbad = (NREG == 16) &&
                   ((w_typ != IMM_S && w_typ != IMM_B && i_inst[11]) ||
                    (w_typ != IMM_U && w_typ != IMM_J && i_inst[19]) ||
                    ((w_typ == IMM_R || w_typ == IMM_S || w_typ == IMM_B) && i_inst[24]));
        w_ill = (i_inst[1:0] != 2'b11) || !w_known || w_regbad;
        o_dec          = '0;
        o_dec.pc       = i_pc;
        o_dec.opcode   = w_opc;
        o_dec.func3    = w_f3;
        o_dec.func7b5  = i_inst[30];
        o_dec.rs1      = i_inst[19:15];
        o_dec.rs2      = i_inst[24:20];
        o_dec.rd       = i_inst[11:7];
        o_dec.imm      = w_ill ? '0 : imm_gen(w_typ, i_inst);
        o_dec.imm_type = w_typ;
        o_dec.op_class = w_cls;
        o_dec.regen    = !w_ill && w_en[2];
        o_dec.pcjen    = !w_ill && w_en[1];
        o_dec.pcren    = !w_ill && w_en[0];
        o_dec.jalen    = !w_ill && w_en[2] && w_en[1];
        o_dec.illegal  = w_ill;
    end
endmodule

// File: rtl/idu_decode_queue.sv
// idu_decode_queue: decodes IFU instructions and buffers the bundles in a DEPTH-entry FIFO toward EXU.
// Build option IDU_RV32M_EN enables MULDIV decode in the decoder.
module idu_decode_queue
    import idu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREG  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output dec_t        out_dec
);
    localparam int AW = $clog2(DEPTH);

    dec_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    dec_t          w_dec;
    logic          w_push, w_pop;

    idu_decode_comb #(.NREG(NREG)) u_dec (.i_pc(in_pc), .i_inst(in_inst), .o_dec(w_dec));

    assign in_ready  = r_count != (AW+1)'(DEPTH);
    assign out_valid = r_count != '0;
    assign out_dec   = r_mem[r_rd];
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_dec;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_idu_decode_queue.sv
// tb_idu_decode_queue: directed checks of decode and queue behaviour for NREG=32 and NREG=16 instances.
module tb_idu_decode_queue;
    import idu_pkg::*;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_pc = 0, in_inst = 0;
    logic        in_ready, out_valid, in_ready16, out_valid16;
    dec_t        out_dec, out_dec16;
    int          n_chk = 0, n_fail = 0;

    idu_decode_queue #(.DEPTH(2), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec));
    idu_decode_queue #(.DEPTH(2), .NREG(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid16), .out_ready(out_ready), .out_dec(out_dec16));

    always #5 clk = ~clk;

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1; in_pc = pc; in_inst = inst; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic pop_one();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_chk++; if (out_dec !== '0) begin n_fail++; $display("FAIL reset_out_dec got=%h exp=0", out_dec); end
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        in_valid = 1; in_pc = 32'h100; in_inst = 32'h00500093; out_ready = 1;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_bypass got=%b exp=0", out_valid); end
        @(posedge clk); #1; in_valid = 0; out_ready = 0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        n_chk++; if (out_dec.rd !== 5'd1 || out_dec.rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", out_dec.rd, out_dec.rs1); end
        n_chk++; if (out_dec.imm !== 32'd5 || out_dec.imm_type !== IMM_I) begin n_fail++; $display("FAIL addi_imm got=%h/%0d exp=5/I", out_dec.imm, out_dec.imm_type); end
        n_chk++; if (out_dec.regen !== 1'b1 || out_dec.illegal !== 1'b0 || out_dec.op_class !== CLS_ALU) begin n_fail++; $display("FAIL addi_ctl got regen=%b ill=%b cls=%0d exp 1/0/ALU", out_dec.regen, out_dec.illegal, out_dec.op_class); end
        pop_one();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_formats();
        push_one(32'h80000010, 32'hFFDFF0EF);
        n_chk++; if (out_dec.imm !== 32'hFFFFFFFC || out_dec.imm_type !== IMM_J || out_dec.pc !== 32'h80000010) begin n_fail++; $display("FAIL jal_imm got imm=%h typ=%0d pc=%h exp FFFFFFFC/J/80000010", out_dec.imm, out_dec.imm_type, out_dec.pc); end
        n_chk++; if ({out_dec.regen, out_dec.pcjen, out_dec.pcren, out_dec.jalen} !== 4'b1111 || out_dec.op_class !== CLS_JAL) begin n_fail++; $display("FAIL jal_en got=%b%b%b%b exp=1111", out_dec.regen, out_dec.pcjen, out_dec.pcren, out_dec.jalen); end
        pop_one();
        push_one(32'h104, 32'h0020A423);
        n_chk++; if (out_dec.imm !== 32'd8 || out_dec.imm_type !== IMM_S || out_dec.regen !== 1'b0 || out_dec.op_class !== CLS_STORE) begin n_fail++; $display("FAIL sw got imm=%h typ=%0d regen=%b exp 8/S/0", out_dec.imm, out_dec.imm_type, out_dec.regen); end
        pop_one();
        push_one(32'h108, 32'h00208463);
        n_chk++; if (out_dec.imm !== 32'd8 || out_dec.imm_type !== IMM_B || {out_dec.regen, out_dec.pcjen, out_dec.pcren, out_dec.jalen} !== 4'b0110) begin n_fail++; $display("FAIL beq got imm=%h typ=%0d en=%b%b%b%b exp 8/B/0110", out_dec.imm, out_dec.imm_type, out_dec.regen, out_dec.pcjen, out_dec.pcren, out_dec.jalen); end
        pop_one();
        push_one(32'h10C, 32'h123452B7);
        n_chk++; if (out_dec.imm !== 32'h12345000 || out_dec.imm_type !== IMM_U || out_dec.rd !== 5'd5 || out_dec.pcren !== 1'b0 || out_dec.op_class !== CLS_LUI) begin n_fail++; $display("FAIL lui got imm=%h typ=%0d rd=%0d exp 12345000/U/5", out_dec.imm, out_dec.imm_type, out_dec.rd); end
        pop_one();
        push_one(32'h110, 32'h402081B3);
        n_chk++; if (out_dec.illegal !== 1'b0 || out_dec.imm !== 32'd0 || out_dec.imm_type !== IMM_R || out_dec.func7b5 !== 1'b1) begin n_fail++; $display("FAIL sub got ill=%b imm=%h typ=%0d exp 0/0/R", out_dec.illegal, out_dec.imm, out_dec.imm_type); end
        pop_one();
        push_one(32'h114, 32'h402091B3);
        n_chk++; if (out_dec.illegal !== 1'b1 || out_dec.regen !== 1'b0) begin n_fail++; $display("FAIL op_f7_20_f3_1 got ill=%b regen=%b exp 1/0", out_dec.illegal, out_dec.regen); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        in_valid = 1; in_pc = 32'h200; in_inst = 32'h00500093; out_ready = 0;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_dec.pc !== 32'h200) begin n_fail++; $display("FAIL fill1 got v=%b r=%b pc=%h exp 1/1/200", out_valid, in_ready, out_dec.pc); end
        in_pc = 32'h204;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill2_full got=%b exp=0", in_ready); end
        in_pc = 32'h208;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b0 || out_dec.pc !== 32'h200) begin n_fail++; $display("FAIL full_hold got r=%b pc=%h exp 0/200", in_ready, out_dec.pc); end
        out_ready = 1;
        @(posedge clk); #1;
        n_chk++; if (out_dec.pc !== 32'h204 || in_ready !== 1'b1) begin n_fail++; $display("FAIL drain1 got pc=%h r=%b exp 204/1", out_dec.pc, in_ready); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1 || out_dec.pc !== 32'h208) begin n_fail++; $display("FAIL drain2 got v=%b pc=%h exp 1/208", out_valid, out_dec.pc); end
        in_valid = 0;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain3 got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_flush();
        push_one(32'h300, 32'h00500093);
        push_one(32'h304, 32'h00500093);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefull got=%b exp=0", in_ready); end
        flush = 1; in_valid = 1; in_pc = 32'h308;
        @(posedge clk); #1; flush = 0; in_valid = 0;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got v=%b r=%b exp 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
        push_one(32'h30C, 32'h00500093);
        n_chk++; if (out_valid !== 1'b1 || out_dec.pc !== 32'h30C) begin n_fail++; $display("FAIL flush_after got v=%b pc=%h exp 1/30C", out_valid, out_dec.pc); end
        pop_one();
    endtask

    task automatic test_illegal();
        push_one(32'h400, 32'h00000000);
        n_chk++; if (out_dec.illegal !== 1'b1 || out_dec.regen !== 1'b0 || out_dec.imm !== 32'd0) begin n_fail++; $display("FAIL zero_inst got ill=%b regen=%b imm=%h exp 1/0/0", out_dec.illegal, out_dec.regen, out_dec.imm); end
        pop_one();
        push_one(32'h404, 32'h01100893);
        n_chk++; if (out_dec16.illegal !== 1'b1 || out_dec16.regen !== 1'b0 || out_valid16 !== 1'b1) begin n_fail++; $display("FAIL rv32e_x17 got ill=%b regen=%b v=%b exp 1/0/1", out_dec16.illegal, out_dec16.regen, out_valid16); end
        n_chk++; if (out_dec.illegal !== 1'b0 || out_dec.rd !== 5'd17 || out_dec.imm !== 32'd17) begin n_fail++; $display("FAIL rv32i_x17 got ill=%b rd=%0d imm=%h exp 0/17/11", out_dec.illegal, out_dec.rd, out_dec.imm); end
        pop_one();
        push_one(32'h408, 32'h00500093);
        n_chk++; if (out_dec16.illegal !== 1'b0) begin n_fail++; $display("FAIL rv32e_x1 got ill=%b exp 0", out_dec16.illegal); end
        pop_one();
    endtask

    task automatic test_muldiv();
        push_one(32'h500, 32'h022081B3);
`ifdef IDU_RV32M_EN
        n_chk++; if (out_dec.illegal !== 1'b0 || out_dec.regen !== 1'b1 || out_dec.op_class !== CLS_MULDIV || out_dec.imm_type !== IMM_R) begin n_fail++; $display("FAIL mul got ill=%b regen=%b cls=%0d exp 0/1/MULDIV", out_dec.illegal, out_dec.regen, out_dec.op_class); end
`else
        n_chk++; if (out_dec.illegal !== 1'b1 || out_dec.regen !== 1'b0) begin n_fail++; $display("FAIL mul got ill=%b regen=%b exp 1/0", out_dec.illegal, out_dec.regen); end
`endif
        pop_one();
    endtask

    task automatic test_async_reset();
        push_one(32'h600, 32'h00500093);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
        #2 rst_n = 0;
        #1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst got v=%b r=%b exp 0/1", out_valid, in_ready); end
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_formats();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_muldiv();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
